// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, LSB-first, with frame-error detection.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_error
);
  localparam int BW = $clog2(DATA_BITS) + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [3:0] tick_cnt, tick_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic done_n, err_n;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      o_data        <= '0;
      o_rx_done     <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      rx_m          <= i_rx;
      rx_s          <= rx_m;
      state         <= state_n;
      tick_cnt      <= tick_n;
      bit_cnt       <= bit_n;
      shreg         <= shreg_n;
      o_data        <= data_n;
      o_rx_done     <= done_n;
      o_frame_error <= err_n;
    end
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    data_n  = o_data;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE:  state_n = rx_s ? IDLE : START;
      START: if (i_tick && tick_cnt == 4'd7) begin
        state_n = rx_s ? IDLE : DATA;
        bit_n   = '0;
      end
      DATA:  if (i_tick && tick_cnt == 4'd15) begin
        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
        bit_n   = bit_cnt + 1'b1;
        state_n = (bit_cnt == BW'(DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP:  if (i_tick && tick_cnt == 4'(STOP_TICKS - 1)) begin
        state_n = IDLE;
        done_n  = rx_s;
        err_n   = !rx_s;
        data_n  = rx_s ? shreg : o_data;
      end
      default: state_n = IDLE;
    endcase
    tick_n = (state_n != state) ? 4'd0 : tick_cnt + 4'(i_tick);
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames against a queue-based scoreboard of expected receiver pulses.
module tb_uart_rx;
  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tick  = 1'b0;
  logic       i_rx    = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_done, o_frame_error;
  int vectors = 0, miscompares = 0;
  int tick_div = 4;
  bit pause = 1'b0;
  typedef struct packed {logic err; logic [7:0] data;} exp_t;
  exp_t sb[$];
  logic [7:0] last_good = 8'h00;

  uart_rx dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_rx(i_rx),
    .o_data(o_data), .o_rx_done(o_rx_done), .o_frame_error(o_frame_error)
  );

  always #5 i_clock = ~i_clock;

  initial begin : tick_gen
    int c;
    c = 0;
    forever begin
      @(posedge i_clock);
      #1;
      if (pause) i_tick = 1'b0;
      else begin
        c = (c + 1 >= tick_div) ? 0 : c + 1;
        i_tick = (c == 0);
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge i_clock); while (!i_tick);
    end
  endtask

  task automatic drive(input logic b, input int n);
    #2 i_rx = b;
    wait_ticks(n);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit stop_ok, input int pause_bit);
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == pause_bit) begin
        drive(d[i], 5);
        pause = 1'b1;
        repeat (1000) @(posedge i_clock);
        pause = 1'b0;
        wait_ticks(11);
      end else drive(d[i], 16);
    end
    if (stop_ok) begin
      sb.push_back({1'b0, d});
      last_good = d;
      drive(1'b1, 16);
    end else begin
      sb.push_back({1'b1, last_good});
      drive(1'b0, 12);
      drive(1'b1, 20);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clock);
      if (o_rx_done || o_frame_error) begin
        vectors++;
        if (o_rx_done && o_frame_error) begin
          miscompares++;
          $display("FAIL both_pulses: rx_done=%b frame_error=%b required not both", o_rx_done, o_frame_error);
        end else if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse: rx_done=%b frame_error=%b data=%h required no pulse", o_rx_done, o_frame_error, o_data);
        end else begin
          e = sb.pop_front();
          if (e.err !== o_frame_error || e.data !== o_data) begin
            miscompares++;
            $display("FAIL frame: got err=%b data=%h expected err=%b data=%h", o_frame_error, o_data, e.err, e.data);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] v;
    repeat (3) @(posedge i_clock);
    #1;
    check("reset_data", o_data, 8'h00);
    check("reset_done", {7'b0, o_rx_done}, 8'h00);
    check("reset_err", {7'b0, o_frame_error}, 8'h00);
    i_reset = 1'b1;
    wait_ticks(20);
    send(8'hA5, 1'b1, -1);
    wait_ticks(4);
    check("data_a5", o_data, 8'hA5);
    drive(1'b0, 4);
    drive(1'b1, 20);
    check("false_start_data", o_data, last_good);
    send(8'h3C, 1'b0, -1);
    check("frame_err_keeps_data", o_data, 8'hA5);
    v = 8'h77;
    drive(1'b0, 16);
    for (int i = 0; i < 3; i++) drive(v[i], 16);
    drive(v[3], 8);
    #2 i_reset = 1'b0;
    #1;
    check("async_reset_data", o_data, 8'h00);
    check("async_reset_done", {7'b0, o_rx_done}, 8'h00);
    check("async_reset_err", {7'b0, o_frame_error}, 8'h00);
    i_rx = 1'b1;
    last_good = 8'h00;
    repeat (5) @(posedge i_clock);
    #1;
    check("held_reset_data", o_data, 8'h00);
    @(negedge i_clock) i_reset = 1'b1;
    wait_ticks(20);
    send(8'h5A, 1'b1, -1);
    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    check("b2b_last", o_data, 8'hFF);
    send(8'hC3, 1'b1, 4);
    check("paused_frame", o_data, 8'hC3);
    for (int n = 0; n < 30; n++) begin
      tick_div = $urandom_range(1, 4);
      send(8'($urandom), $urandom_range(0, 4) != 0, -1);
      wait_ticks($urandom_range(0, 3));
    end
    wait_ticks(40);
    check("final_data", o_data, last_good);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL pending: %0d expected pulses never seen, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 The module SHALL have parameter STOP_TICKS, default 16, number of oversampling ticks in the stop bit.
REQ-003 The module SHALL have port i_clock, input, 1 bit, system clock; all state changes on rising edge.
REQ-004 The module SHALL have port i_reset, input, 1 bit, asynchronous, active-low reset.
REQ-005 The module SHALL have port i_tick, input, 1 bit, 16x-baud oversampling strobe, one i_clock wide, from the baud rate generator.
REQ-006 The module SHALL have port i_rx, input, 1 bit, asynchronous serial line, idle high.
REQ-007 The module SHALL have port o_data, output, DATA_BITS bits, last correctly framed received word.
REQ-008 The module SHALL have port o_rx_done, output, 1 bit, one-i_clock pulse when o_data is updated.
REQ-009 The module SHALL have port o_frame_error, output, 1 bit, one-i_clock pulse when the stop bit samples low.

Function
REQ-010 The module SHALL pass i_rx through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rx_s).
REQ-011 The module SHALL implement states IDLE, START, DATA and STOP.
REQ-012 The module SHALL keep a 4-bit tick counter that advances only on cycles with i_tick=1 and clears on every state change.
REQ-013 In IDLE, rx_s=0 SHALL move the FSM to START on the next edge, independent of i_tick.
REQ-014 In START, on the tick where the counter equals 7 (mid start bit), rx_s=0 SHALL move the FSM to DATA, and rx_s=1 SHALL return it to IDLE as a false start with no output pulse.
REQ-015 In DATA, on the tick where the counter equals 15, the module SHALL sample rx_s LSB-first into a shift register (shift right, new bit enters the MSB) and increment a bit counter.
REQ-016 After DATA_BITS samples the module SHALL move to STOP; the bit counter width SHALL be clog2(DATA_BITS)+1.
REQ-017 In STOP, on the tick where the counter equals STOP_TICKS-1, rx_s=1 SHALL load o_data from the shift register and pulse o_rx_done on the following cycle.
REQ-018 In STOP, on the same tick, rx_s=0 SHALL pulse o_frame_error, leave o_data unchanged, and discard the frame.
REQ-019 The FSM SHALL return to IDLE in both STOP cases.
REQ-020 o_rx_done and o_frame_error SHALL be registered, SHALL last exactly one i_clock, and SHALL never assert together.
REQ-021 If i_tick stays low, the FSM SHALL hold state, counters and shift register indefinitely.
REQ-022 Line activity during DATA or STOP, other than at the sample tick, SHALL have no effect.
REQ-023 A start bit SHALL be accepted in the cycle after the FSM returns to IDLE, so back-to-back frames are supported.

Reset
REQ-024 i_reset=0 SHALL immediately (asynchronously) force state=IDLE, all counters=0, shift register=0, o_data=0, o_rx_done=0, o_frame_error=0, and both synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse.
REQ-026 After reset release, reception SHALL restart from the next falling edge of rx_s.

Verification
REQ-027 Scenario: i_tick every 4th clock; send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> one o_rx_done pulse, o_data=0xA5, o_frame_error=0.
REQ-028 Scenario: drive i_rx low for 4 ticks, then high -> FSM back to IDLE, no pulses, o_data unchanged.
REQ-029 Scenario: after 0xA5, send 0x3C with stop bit 0 -> one o_frame_error pulse, no o_rx_done, o_data stays 0xA5.
REQ-030 Scenario: assert i_reset during data bit 3 of 0x77, then release and send 0x5A -> outputs 0 during reset, then o_data=0x5A with one o_rx_done.
REQ-031 Scenario: send 0x00 and 0xFF back-to-back with no idle gap -> two o_rx_done pulses, o_data=0x00 then 0xFF.
REQ-032 Scenario: hold i_tick=0 for 1000 cycles in mid-frame, then resume -> frame completes correctly, no extra pulses.
